// File: rtl/params_bank_sched.sv
// Bank-switch scheduler for a banked parameter RAM. Host requests are held
// pending and launched only on a frame boundary. Outputs are registered.
module params_bank_sched #(
    parameter int BANK_NUM   = 2,
    parameter int BANK_WIDTH = 1,
    parameter int BUSY_WAIT  = 4,
    parameter int INIT_BANK  = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  frame_start,
    input  logic                  ctl_update_req,
    input  logic [BANK_WIDTH-1:0] ctl_bank,
    output logic [BANK_WIDTH-1:0] ctl_active_bank,
    output logic                  ctl_pending,
    output logic                  ctl_busy,
    output logic                  ctl_done,
    output logic                  ctl_overwrite,
    output logic                  ctl_reject,
    output logic                  ctl_timeout,
    output logic                  param_start,
    output logic [BANK_WIDTH-1:0] param_bank,
    input  logic                  param_busy
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_BUSY = 3'd2,
        LOAD      = 3'd3,
        DONE      = 3'd4
    } state_t;

    localparam logic [BANK_WIDTH-1:0] INIT     = INIT_BANK[BANK_WIDTH-1:0];
    localparam logic [BANK_WIDTH:0]   BANK_LIM = BANK_NUM[BANK_WIDTH:0];
    localparam logic [7:0]            WAIT_LIM = BUSY_WAIT[7:0];

    state_t                state, state_next;
    logic [7:0]            cnt, cnt_next, cnt_inc;
    logic                  timeout_next;
    logic [BANK_WIDTH-1:0] pend_bank, launch_bank;
    logic                  req_valid, launch;

    // A same-cycle request takes priority over the older pending one.
    assign req_valid   = ctl_update_req && ({1'b0, ctl_bank} < BANK_LIM);
    assign launch      = (state == IDLE) && frame_start && (ctl_pending || req_valid);
    assign launch_bank = req_valid ? ctl_bank : pend_bank;
    assign cnt_inc     = cnt + 8'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        timeout_next = 1'b0;
        case (state)
            IDLE:      if (launch) state_next = START;
            START: begin
                state_next = WAIT_BUSY;
                cnt_next   = '0;
            end
            WAIT_BUSY: begin
                if (param_busy) begin
                    state_next = LOAD;
                end else begin
                    cnt_next = cnt_inc;
                    if (cnt_inc == WAIT_LIM) begin
                        state_next   = DONE;
                        timeout_next = 1'b1;
                    end
                end
            end
            LOAD:      if (!param_busy) state_next = DONE;
            DONE:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctl_pending     <= 1'b0;
            pend_bank       <= '0;
            ctl_overwrite   <= 1'b0;
            ctl_reject      <= 1'b0;
            ctl_timeout     <= 1'b0;
            ctl_done        <= 1'b0;
            ctl_busy        <= 1'b0;
            ctl_active_bank <= INIT;
            param_start     <= 1'b0;
            param_bank      <= INIT;
        end else begin
            ctl_reject    <= ctl_update_req && !req_valid;
            // A request consumed by the launch it arrives with never overwrites.
            ctl_overwrite <= req_valid && ctl_pending && !launch;
            if (req_valid) pend_bank <= ctl_bank;
            if (launch)
                ctl_pending <= 1'b0;
            else if (req_valid)
                ctl_pending <= 1'b1;

            if (launch) param_bank <= launch_bank;
            param_start <= (state_next == START);
            ctl_busy    <= (state_next != IDLE);
            ctl_timeout <= timeout_next;
            ctl_done    <= (state == DONE);
            if (state == DONE) ctl_active_bank <= param_bank;
        end
    end

endmodule

// File: tb/tb_params_bank_sched.sv
// Directed bench for params_bank_sched: launch timing, overwrite/reject,
// requests during a load, busy timeout and reset mid-load.
module tb_params_bank_sched;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       frame_start;
    logic       ctl_update_req;
    logic [1:0] ctl_bank;
    logic [1:0] ctl_active_bank;
    logic       ctl_pending, ctl_busy, ctl_done, ctl_overwrite;
    logic       ctl_reject, ctl_timeout, param_start, param_busy;
    logic [1:0] param_bank;

    int total = 0;
    int bad   = 0;
    int seen_done;

    params_bank_sched #(
        .BANK_NUM(2), .BANK_WIDTH(2), .BUSY_WAIT(4), .INIT_BANK(0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
        .ctl_update_req(ctl_update_req), .ctl_bank(ctl_bank),
        .ctl_active_bank(ctl_active_bank), .ctl_pending(ctl_pending),
        .ctl_busy(ctl_busy), .ctl_done(ctl_done), .ctl_overwrite(ctl_overwrite),
        .ctl_reject(ctl_reject), .ctl_timeout(ctl_timeout),
        .param_start(param_start), .param_bank(param_bank), .param_busy(param_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0; frame_start = 1'b0; ctl_update_req = 1'b0;
        ctl_bank = 2'd0; param_busy = 1'b0;
        tick(); tick();
        chk("rst_start",   param_start, 0);
        chk("rst_pbank",   param_bank, 0);
        chk("rst_active",  ctl_active_bank, 0);
        chk("rst_pending", ctl_pending, 0);
        chk("rst_busy",    ctl_busy, 0);
        chk("rst_done",    ctl_done, 0);
        reset_n = 1'b1;
        tick();

        // Basic load: request bank 1, frame 5 cycles later
        ctl_update_req = 1'b1; ctl_bank = 2'd1;
        tick();
        ctl_update_req = 1'b0;
        chk("b_pending", ctl_pending, 1);
        repeat (4) tick();
        chk("b_no_start", param_start, 0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("b_start",    param_start, 1);
        chk("b_pbank",    param_bank, 1);
        chk("b_busy",     ctl_busy, 1);
        chk("b_pend_clr", ctl_pending, 0);
        param_busy = 1'b1;
        tick();
        chk("b_start_1cyc", param_start, 0);
        repeat (4) tick();
        param_busy = 1'b0;
        tick();
        chk("b_done_early", ctl_done, 0);
        chk("b_busy_done",  ctl_busy, 1);
        chk("b_active_old", ctl_active_bank, 0);
        tick();
        chk("b_done",     ctl_done, 1);
        chk("b_active",   ctl_active_bank, 1);
        chk("b_idle",     ctl_busy, 0);
        chk("b_pend_end", ctl_pending, 0);
        tick();
        chk("b_done_once", ctl_done, 0);

        // Same-cycle request and frame
        ctl_update_req = 1'b1; ctl_bank = 2'd0; frame_start = 1'b1;
        tick();
        ctl_update_req = 1'b0; frame_start = 1'b0;
        chk("s_start", param_start, 1);
        chk("s_pbank", param_bank, 0);
        chk("s_no_ovw", ctl_overwrite, 0);
        chk("s_pend",  ctl_pending, 0);
        param_busy = 1'b1;
        tick(); tick();
        param_busy = 1'b0;
        tick(); tick();
        chk("s_done",   ctl_done, 1);
        chk("s_active", ctl_active_bank, 0);

        // Overwrite then reject
        ctl_update_req = 1'b1; ctl_bank = 2'd1;
        tick();
        chk("o_first_no_ovw", ctl_overwrite, 0);
        ctl_bank = 2'd0;
        tick();
        chk("o_ovw", ctl_overwrite, 1);
        chk("o_no_rej", ctl_reject, 0);
        ctl_bank = 2'd2;
        tick();
        ctl_update_req = 1'b0;
        chk("o_rej",     ctl_reject, 1);
        chk("o_ovw_one", ctl_overwrite, 0);
        tick();
        chk("o_rej_one", ctl_reject, 0);
        chk("o_pending", ctl_pending, 1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("o_start", param_start, 1);
        chk("o_pbank", param_bank, 0);
        param_busy = 1'b1;
        tick(); tick();
        param_busy = 1'b0;
        tick(); tick();
        chk("o_done", ctl_done, 1);

        // Request during a load, frame during load is ignored
        ctl_update_req = 1'b1; ctl_bank = 2'd0; frame_start = 1'b1;
        tick();
        ctl_update_req = 1'b0; frame_start = 1'b0;
        param_busy = 1'b1;
        tick(); tick();
        ctl_update_req = 1'b1; ctl_bank = 2'd1;
        tick();
        ctl_update_req = 1'b0;
        chk("l_pending", ctl_pending, 1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("l_no_start", param_start, 0);
        chk("l_pbank_hold", param_bank, 0);
        param_busy = 1'b0;
        tick(); tick();
        chk("l_done",     ctl_done, 1);
        chk("l_active",   ctl_active_bank, 0);
        chk("l_pend_mid", ctl_pending, 1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("l_start", param_start, 1);
        chk("l_pbank", param_bank, 1);
        chk("l_pend_clr", ctl_pending, 0);

        // Timeout: RAM never raises busy
        tick();
        repeat (3) tick();
        chk("t_not_yet", ctl_timeout, 0);
        tick();
        chk("t_timeout", ctl_timeout, 1);
        chk("t_no_done", ctl_done, 0);
        tick();
        chk("t_pulse",  ctl_timeout, 0);
        chk("t_done",   ctl_done, 1);
        chk("t_active", ctl_active_bank, 1);
        tick();

        // Reset during LOAD
        ctl_update_req = 1'b1; ctl_bank = 2'd0; frame_start = 1'b1;
        tick();
        ctl_update_req = 1'b0; frame_start = 1'b0;
        param_busy = 1'b1;
        tick(); tick();
        chk("r_in_load", ctl_busy, 1);
        reset_n = 1'b0;
        #1;
        chk("r_start",  param_start, 0);
        chk("r_busy",   ctl_busy, 0);
        chk("r_active", ctl_active_bank, 0);
        param_busy = 1'b0;
        tick();
        reset_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ctl_done) seen_done++;
        end
        chk("r_no_done", seen_done, 0);
        chk("r_idle",    ctl_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
